wptr_handler: RTL and testbench

//  Write-side pointer/flag logic of the async FIFO; write-domain mirror of the read-pointer block.

---
 rtl/wptr_handler.sv | 74 +++++++
 tb/tb_wptr_handler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wptr_handler.sv
// Write-side pointer and flag logic of the async FIFO: binary/Gray write pointers plus
// registered full, almost_full, fill level, write acknowledge and sticky overflow.
module wptr_handler #(
    parameter int PTR_WIDTH = 8,
    parameter int AF_LEVEL  = (1 << PTR_WIDTH) - 2
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               w_en,
    input  logic [PTR_WIDTH:0] g_rptr_sync,
    input  logic               overflow_clr,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wr_level,
    output logic               w_ack,
    output logic               overflow
);

    localparam logic [PTR_WIDTH:0] AF_THR = AF_LEVEL[PTR_WIDTH:0];

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic               wr_acc;
    logic [PTR_WIDTH:0] b_wptr_next;
    logic [PTR_WIDTH:0] g_wptr_next;
    logic [PTR_WIDTH:0] b_rptr_s;
    logic [PTR_WIDTH:0] level_next;
    logic [PTR_WIDTH:0] g_full_cmp;

    always_comb begin
        wr_acc      = w_en & ~full;
        b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, wr_acc};
        g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;
        b_rptr_s    = gray2bin(g_rptr_sync);
        // Level uses the lagging synchronised read pointer, so it can only overstate fill.
        level_next  = b_wptr_next - b_rptr_s;
        // In Gray code, "one lap ahead" means the two MSBs inverted, the rest equal.
        g_full_cmp  = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            w_ack       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_wptr_next;
            g_wptr      <= g_wptr_next;
            full        <= (g_wptr_next == g_full_cmp);
            almost_full <= (level_next >= AF_THR);
            wr_level    <= level_next;
            w_ack       <= wr_acc;
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_handler.sv
// Scoreboard bench for wptr_handler (PTR_WIDTH=3): stimulus pushes expected outputs,
// a monitor pops and compares them one cycle later.
module tb_wptr_handler;

    localparam int PW = 3;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          overflow_clr = 1'b0;
    logic [PW:0]   g_rptr_sync = '0;
    logic [PW:0]   b_wptr;
    logic [PW:0]   g_wptr;
    logic          full;
    logic          almost_full;
    logic [PW:0]   wr_level;
    logic          w_ack;
    logic          overflow;

    wptr_handler #(.PTR_WIDTH(PW), .AF_LEVEL(6)) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .w_en(w_en),
        .g_rptr_sync(g_rptr_sync),
        .overflow_clr(overflow_clr),
        .b_wptr(b_wptr),
        .g_wptr(g_wptr),
        .full(full),
        .almost_full(almost_full),
        .wr_level(wr_level),
        .w_ack(w_ack),
        .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] lvl;
        logic       f;
        logic       af;
        logic       ack;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: counts of accepted writes and of reads, never pointer arithmetic.
    int   m_wcnt = 0;
    int   m_rc   = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t hv(input logic [3:0] b, input logic [3:0] g, input logic f,
                                input logic af, input logic [3:0] lvl, input logic ack,
                                input logic ovf);
        exp_t e;
        e.b = b; e.g = g; e.f = f; e.af = af; e.lvl = lvl; e.ack = ack; e.ovf = ovf;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check_vec(input exp_t e);
        chk("b_wptr", int'(b_wptr), int'(e.b));
        chk("g_wptr", int'(g_wptr), int'(e.g));
        chk("full", int'(full), int'(e.f));
        chk("almost_full", int'(almost_full), int'(e.af));
        chk("wr_level", int'(wr_level), int'(e.lvl));
        chk("w_ack", int'(w_ack), int'(e.ack));
        chk("overflow", int'(overflow), int'(e.ovf));
    endtask

    task automatic check_zero();
        check_vec(hv(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    endtask

    task automatic step(input logic we, input int rc, input logic clr,
                        input logic hand, input exp_t hvec);
        exp_t e;
        int   lvl;
        logic acc;
        @(negedge wclk);
        w_en         = we;
        g_rptr_sync  = to_gray(rc);
        overflow_clr = clr;
        acc = we && !m_full;
        if (we && m_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (acc) m_wcnt++;
        m_rc   = rc;
        lvl    = m_wcnt - rc;
        m_full = (lvl == 8);
        e.b   = m_wcnt[3:0];
        e.g   = to_gray(m_wcnt);
        e.lvl = lvl[3:0];
        e.f   = m_full;
        e.af  = (lvl >= 6);
        e.ack = acc;
        e.ovf = m_ovf;
        q.push_back(hand ? hvec : e);
    endtask

    task automatic step_m(input logic we, input int rc, input logic clr);
        step(we, rc, clr, 1'b0, '0);
    endtask

    // Monitor: DUT outputs are registered every cycle, so each edge presents one result.
    initial begin
        exp_t       e;
        logic [3:0] prev_g;
        prev_g = '0;
        forever begin
            @(posedge wclk);
            #1;
            if (!wrst_n) begin
                prev_g = '0;
            end else begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check_vec(e);
                end
                if (g_wptr != prev_g) chk("gray_single_bit", $countones(g_wptr ^ prev_g), 1);
                prev_g = g_wptr;
            end
        end
    end

    initial begin
        int w1;
        int w2;
        int rc;
        #2;
        check_zero();
        @(negedge wclk);
        wrst_n = 1'b1;

        // Reset asserted mid-burst
        step_m(1'b1, 0, 1'b0);
        step_m(1'b1, 0, 1'b0);
        step_m(1'b1, 0, 1'b0);
        @(posedge wclk);
        #3;
        wrst_n = 1'b0;
        #1;
        check_zero();
        @(posedge wclk);
        #2;
        check_zero();
        @(negedge wclk);
        wrst_n = 1'b1;
        w_en = 1'b0;
        g_rptr_sync = '0;
        m_wcnt = 0; m_rc = 0; m_full = 1'b0; m_ovf = 1'b0;
        step(1'b1, 0, 1'b0, 1'b1, hv(4'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0));

        // Fill to full
        for (int i = 2; i <= 8; i++) begin
            if (i == 6)
                step(1'b1, 0, 1'b0, 1'b1, hv(4'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0));
            else if (i == 8)
                step(1'b1, 0, 1'b0, 1'b1, hv(4'b1000, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0));
            else
                step_m(1'b1, 0, 1'b0);
        end

        // Overflow while full, clear priority
        step(1'b1, 0, 1'b0, 1'b1, hv(4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1));
        step(1'b1, 0, 1'b0, 1'b1, hv(4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1));
        step(1'b1, 0, 1'b1, 1'b1, hv(4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b1));
        step(1'b0, 0, 1'b1, 1'b1, hv(4'd8, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0));

        // Reader frees one slot, then refill
        step(1'b0, 1, 1'b0, 1'b1, hv(4'd8, 4'b1100, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0));
        step(1'b1, 1, 1'b0, 1'b1, hv(4'd9, 4'b1101, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0));

        // Drain completely
        for (int r = 2; r <= 9; r++) step_m(1'b0, r, 1'b0);

        // Streaming wrap with read pointer lagging two cycles
        w1 = m_wcnt;
        w2 = m_wcnt;
        for (int k = 0; k < 20; k++) begin
            step_m(1'b1, w2, 1'b0);
            w2 = w1;
            w1 = m_wcnt;
        end

        // Random traffic with a slower reader
        rc = m_rc;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0 && rc < m_wcnt) rc++;
            step_m($urandom_range(0, 3) != 0, rc, $urandom_range(0, 15) == 0);
        end

        @(negedge wclk);
        w_en = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(posedge wclk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
